// File: rtl/xbar_slave_mem.sv
// Purpose: slave-side RAM endpoint behind cross_bar; services one routed read/write request at a time.
// Latency: ack one cycle after capture, access WS+1 edges after capture, resp/err pulse in the cycle after access.
// Backpressure: req is ignored while busy and never queued; the master holds req until it sees ack.
module xbar_slave_mem #(
   parameter int unsigned AW       = 3,
   parameter int unsigned WS       = 2,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        cmd,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic        busy,
   output logic [31:0] rdata,
   output logic        resp,
   output logic        err
);

   localparam int unsigned DEPTH  = 1 << AW;
   localparam logic [3:0]  WS_CNT = 4'(WS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            cmd_q, cmd_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            oor_q, oor_d;
   logic            ack_q, ack_d;
   logic            busy_q, busy_d;
   logic            resp_q, resp_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            mem_we;

   logic [31:0]     mem_q [DEPTH];

   // Any set bit between the slave-select bit and the RAM index is an access past the end of this RAM.
   logic            addr_oor;
   assign addr_oor = |addr[30:AW];

   // Bit 31 picked this slave upstream; nothing left to decode here.
   logic            unused_sel;
   assign unused_sel = addr[31];

   // Next-state and registered-output logic; pulses default low so they last a single cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      oor_d   = oor_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      resp_d  = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      mem_we  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               cmd_d   = cmd;
               idx_d   = addr[AW-1:0];
               wdata_d = wdata;
               oor_d   = addr_oor;
               ack_d   = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = WS_CNT;
               state_d = (WS_CNT != 4'd0) ? S_WAIT : S_ACCESS;
            end
         end

         S_WAIT: begin
            // The counter holds the wait cycles still to run including this one.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_ACCESS;
            end
         end

         S_ACCESS: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (oor_q) begin
               err_d = 1'b1;
               if (!cmd_q) begin
                  rdata_d = ERR_DATA;
                  resp_d  = 1'b1;
               end
            end else if (!cmd_q) begin
               rdata_d = mem_q[idx_q];
               resp_d  = 1'b1;
            end else begin
               mem_we = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset; an in-flight transaction is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         cmd_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         oor_q   <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         oor_q   <= oor_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM write port; contents survive reset, but a write coinciding with reset is not committed.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign ack   = ack_q;
   assign busy  = busy_q;
   assign rdata = rdata_q;
   assign resp  = resp_q;
   assign err   = err_q;

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Bench for xbar_slave_mem: one instance with WS=2 and one with WS=0, both AW=3.
// Stimulus is driven and outputs sampled on the falling edge.
// Expectations come from an array-based memory model and the transaction timing rules.
module tb_xbar_slave_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        req2, req0, cmd;
   logic [31:0] addr, wdata;
   logic        ack2, busy2, resp2, err2;
   logic        ack0, busy0, resp0, err0;
   logic [31:0] rdata2, rdata0;

   always #5 clk = ~clk;

   xbar_slave_mem #(.AW(3), .WS(2), .ERR_DATA(32'hDEADBEEF)) u_dut (
      .clk(clk), .rst(rst), .req(req2), .cmd(cmd), .addr(addr), .wdata(wdata),
      .ack(ack2), .busy(busy2), .rdata(rdata2), .resp(resp2), .err(err2)
   );

   xbar_slave_mem #(.AW(3), .WS(0), .ERR_DATA(32'hDEADBEEF)) u_dut_ws0 (
      .clk(clk), .rst(rst), .req(req0), .cmd(cmd), .addr(addr), .wdata(wdata),
      .ack(ack0), .busy(busy0), .rdata(rdata0), .resp(resp0), .err(err0)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] mem2 [8];
   logic [31:0] mem0 [8];
   logic [31:0] last2 = 32'd0;
   logic [31:0] last0 = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, got, exp);
   endtask

   // w=1 selects the WS=0 instance, w=0 the WS=2 instance.
   task automatic expect_out(input bit w, input string tag, input logic a, input logic b,
                             input logic r, input logic e, input logic [31:0] d);
      check({tag, ".ack"},   32'(w ? ack0  : ack2),  32'(a));
      check({tag, ".busy"},  32'(w ? busy0 : busy2), 32'(b));
      check({tag, ".resp"},  32'(w ? resp0 : resp2), 32'(r));
      check({tag, ".err"},   32'(w ? err0  : err2),  32'(e));
      check({tag, ".rdata"}, w ? rdata0 : rdata2,    d);
   endtask

   task automatic set_req(input bit w, input logic v);
      if (w) req0 = v;
      else   req2 = v;
   endtask

   // Entered and left on a falling edge with the instance idle.
   task automatic txn(input bit w, input bit c, input logic [31:0] a, input logic [31:0] d,
                      input bit keep);
      int          ws;
      int          idx;
      bit          oor;
      logic [31:0] held;
      logic [31:0] exp_rd;
      ws     = w ? 0 : 2;
      idx    = int'(a & 32'd7);
      oor    = (a & 32'h7FFF_FFF8) != 32'd0;
      held   = w ? last0 : last2;
      exp_rd = held;
      if (!c) exp_rd = oor ? 32'hDEADBEEF : (w ? mem0[idx] : mem2[idx]);

      set_req(w, 1'b1);
      cmd = c; addr = a; wdata = d;
      @(negedge clk);
      if (!keep) set_req(w, 1'b0);
      expect_out(w, "capture", 1'b1, 1'b1, 1'b0, 1'b0, held);
      for (int j = 0; j < ws; j++) begin
         @(negedge clk);
         expect_out(w, "wait", 1'b0, 1'b1, 1'b0, 1'b0, held);
      end
      @(negedge clk);
      expect_out(w, "access", 1'b0, 1'b0, !c, oor, exp_rd);

      if (c && !oor) begin
         if (w) mem0[idx] = d;
         else   mem2[idx] = d;
      end
      if (!c) begin
         if (w) last0 = exp_rd;
         else   last2 = exp_rd;
      end
   endtask

   task automatic idle(input bit w, input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         expect_out(w, "idle", 1'b0, 1'b0, 1'b0, 1'b0, w ? last0 : last2);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra;
      bit          rc;
      bit          rk;

      rst = 1'b1; req2 = 1'b1; req0 = 1'b1; cmd = 1'b1; addr = 32'd0; wdata = 32'd0;

      // Reset held with req high: everything stays quiet.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_out(1'b0, "reset2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
         expect_out(1'b1, "reset0", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      end
      rst = 1'b0; req0 = 1'b0;

      // First capture at the edge right after release.
      txn(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);

      // Write then read back through the slave-select bit.
      txn(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0015, 1'b0);
      txn(1'b0, 1'b0, 32'h8000_0005, 32'h0, 1'b0);
      idle(1'b0, 2);

      // Burst fill and readback with req held continuously.
      for (int i = 0; i < 8; i++) txn(1'b0, 1'b1, 32'(i), 32'h51 + 32'(i), 1'b1);
      for (int i = 0; i < 8; i++) txn(1'b0, 1'b0, 32'(i), 32'h0, i != 7);
      idle(1'b0, 2);

      // Out of range: dropped write, then sentinel read data.
      txn(1'b0, 1'b1, 32'h0000_0008, 32'h0000_00A1, 1'b0);
      txn(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
      txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
      idle(1'b0, 1);

      // Zero wait states: fill, then back-to-back reads every two cycles.
      for (int i = 0; i < 8; i++) txn(1'b1, 1'b1, 32'(i), 32'h51 + 32'(i), 1'b1);
      txn(1'b1, 1'b0, 32'h0000_0003, 32'h0, 1'b1);
      txn(1'b1, 1'b0, 32'h0000_0006, 32'h0, 1'b0);
      idle(1'b1, 2);

      // Reset lands during WAIT of a write: nothing commits, nothing responds.
      req2 = 1'b1; cmd = 1'b1; addr = 32'h0000_0002; wdata = 32'h0000_00FF;
      @(negedge clk);
      req2 = 1'b0;
      expect_out(1'b0, "midrst.capture", 1'b1, 1'b1, 1'b0, 1'b0, last2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last2 = 32'd0; last0 = 32'd0;
      expect_out(1'b0, "midrst.reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      idle(1'b0, 4);
      txn(1'b0, 1'b0, 32'h0000_0002, 32'h0, 1'b0);

      // Randomized traffic on both instances.
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 30; i++) begin
            rc = 1'($urandom_range(0, 1));
            rk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0)
               ra = $urandom | (32'h1 << $urandom_range(3, 30));
            else
               ra = ($urandom & 32'h8000_0000) | 32'($urandom_range(0, 7));
            txn(w[0], rc, ra, $urandom, rk);
         end
         set_req(w[0], 1'b0);
         idle(w[0], 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
